// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave bridging into a 4 KiB, four-bank SRAM window with a fixed read latency.
// Define WB_SRAM_RANGE_CHECK_EN to error out strobes outside BASE_ADDR[31:12] instead of aliasing them.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic [31:0]   wbs_dat_o,
  output logic [31:0]   sram_addr_o,
  output logic          sram_en_o,
  output logic          sram_web_o,
  output logic [3:0]    sram_wmask_o,
  output logic [31:0]   sram_din_o,
  input  logic [127:0]  sram_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        lat_we;
  logic [3:0]  lat_sel;
  logic        req, in_range, accept, capture;

  assign req = wbs_cyc_i & wbs_stb_i;

`ifdef WB_SRAM_RANGE_CHECK_EN
  assign in_range = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);

  // Error is a single-cycle pulse; the guard stops a lingering strobe from being errored twice.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wbs_err_o <= 1'b0;
    else          wbs_err_o <= (state == IDLE) & req & ~in_range & ~wbs_err_o;
  end
`else
  logic unused_base;
  assign unused_base = ^BASE_ADDR;
  assign in_range    = 1'b1;
  assign wbs_err_o   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req && in_range && !wbs_err_o) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (lat_we) begin
          state_next = ACK;
        end else begin
          state_next = WAIT;
          cnt_next   = 2'(READ_LATENCY);
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end else if (cnt == 2'd1) begin
          state_next = ACK;
          capture    = 1'b1;
          cnt_next   = 2'd0;
        end else begin
          cnt_next   = cnt - 2'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request fields are held for the whole transaction so the SRAM sees stable address/data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sram_addr_o <= 32'h0;
      sram_din_o  <= 32'h0;
      lat_we      <= 1'b0;
      lat_sel     <= 4'h0;
    end else if (accept) begin
      sram_addr_o <= wbs_adr_i;
      sram_din_o  <= wbs_dat_i;
      lat_we      <= wbs_we_i;
      lat_sel     <= wbs_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_dat_o <= 32'h0;
    end else if (capture) begin
      case (sram_addr_o[11:10])
        2'b00:   wbs_dat_o <= sram_dout_i[31:0];
        2'b01:   wbs_dat_o <= sram_dout_i[63:32];
        2'b10:   wbs_dat_o <= sram_dout_i[95:64];
        default: wbs_dat_o <= sram_dout_i[127:96];
      endcase
    end
  end

  assign sram_en_o    = (state == ACCESS);
  assign sram_web_o   = ~(sram_en_o & lat_we);
  assign sram_wmask_o = (sram_en_o & lat_we) ? lat_sel : 4'b0000;
  assign wbs_ack_o    = (state == ACK);

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed self-checking bench for wb_sram_bridge at the default READ_LATENCY of 1.
// Expected values are hand-derived; WB_SRAM_RANGE_CHECK_EN selects the out-of-window expectations.
module tb_wb_sram_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat;
  logic         ack, err;
  logic [31:0]  dat_o;
  logic [31:0]  sram_addr;
  logic         sram_en, sram_web;
  logic [3:0]   sram_wmask;
  logic [31:0]  sram_din;
  logic [127:0] sram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt, en_cnt;
  logic [31:0] last_rd;

  localparam logic [31:0] BANK0 = 32'hA0A0_A0A0;
  localparam logic [31:0] BANK1 = 32'hB1B1_B1B1;
  localparam logic [31:0] BANK2 = 32'hC2C2_C2C2;
  localparam logic [31:0] BANK3 = 32'h1234_5678;

  always #5 clk = ~clk;

  wb_sram_bridge dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (ack),
    .wbs_err_o    (err),
    .wbs_dat_o    (dat_o),
    .sram_addr_o  (sram_addr),
    .sram_en_o    (sram_en),
    .sram_web_o   (sram_web),
    .sram_wmask_o (sram_wmask),
    .sram_din_o   (sram_din),
    .sram_dout_i  (sram_dout)
  );

  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    cyc = c; stb = s; we = w; sel = b; adr = a; dat = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample one time unit after the rising edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    sram_dout = {BANK3, BANK2, BANK1, BANK0};
    idleBus();
    rst = 1'b1;
    #1;
    checkOutput("rst_ack",   32'(ack),        32'h0);
    checkOutput("rst_err",   32'(err),        32'h0);
    checkOutput("rst_dat_o", dat_o,           32'h0);
    checkOutput("rst_en",    32'(sram_en),    32'h0);
    checkOutput("rst_web",   32'(sram_web),   32'h1);
    checkOutput("rst_wmask", 32'(sram_wmask), 32'h0);
    checkOutput("rst_addr",  sram_addr,       32'h0);
    checkOutput("rst_din",   sram_din,        32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] single write to bank 2");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 32'h3000_0804, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_en",     32'(sram_en),         32'h1);
    checkOutput("wr_web",    32'(sram_web),        32'h0);
    checkOutput("wr_wmask",  32'(sram_wmask),      32'hF);
    checkOutput("wr_bank",   32'(sram_addr[11:10]), 32'h2);
    checkOutput("wr_din",    sram_din,             32'hDEAD_BEEF);
    checkOutput("wr_ack_n1", 32'(ack),             32'h0);
    tick();
    checkOutput("wr_ack_n2", 32'(ack),        32'h1);
    checkOutput("wr_en_off", 32'(sram_en),    32'h0);
    checkOutput("wr_web_off",32'(sram_web),   32'h1);
    checkOutput("wr_dat_o",  dat_o,           32'h0);
    idleBus();
    tick();
    checkOutput("wr_ack_drop", 32'(ack), 32'h0);

    $display("[TB] single read from bank 3");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0C10, 32'h0);
    tick();
    checkOutput("rd_en",     32'(sram_en),    32'h1);
    checkOutput("rd_web",    32'(sram_web),   32'h1);
    checkOutput("rd_wmask",  32'(sram_wmask), 32'h0);
    tick();
    checkOutput("rd_ack_n2", 32'(ack), 32'h0);
    tick();
    checkOutput("rd_ack_n3", 32'(ack), 32'h1);
    checkOutput("rd_dat_o",  dat_o,    BANK3);
    idleBus();
    tick();
    checkOutput("rd_ack_drop", 32'(ack), 32'h0);

    $display("[TB] back-to-back write then read with strobe held");
    ack_cnt = 0;
    en_cnt  = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 32'h3000_0000, 32'h1122_3344);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sram_en) en_cnt++;
      if (ack) begin
        ack_cnt++;
        if (ack_cnt == 1) applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0404, 32'h0);
        else              idleBus();
      end
    end
    checkOutput("b2b_acks",  32'(ack_cnt), 32'd2);
    checkOutput("b2b_ens",   32'(en_cnt),  32'd2);
    checkOutput("b2b_dat_o", dat_o,        BANK1);

    $display("[TB] reset during read wait");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0800, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_en",    32'(sram_en),    32'h0);
    checkOutput("mid_rst_web",   32'(sram_web),   32'h1);
    checkOutput("mid_rst_wmask", 32'(sram_wmask), 32'h0);
    checkOutput("mid_rst_ack",   32'(ack),        32'h0);
    checkOutput("mid_rst_addr",  sram_addr,       32'h0);
    checkOutput("mid_rst_din",   sram_din,        32'h0);
    checkOutput("mid_rst_dat_o", dat_o,           32'h0);
    idleBus();
    tick();
    rst = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) ack_cnt++;
    end
    checkOutput("mid_rst_no_ack", 32'(ack_cnt), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'hC, 32'h3000_0010, 32'hCAFE_F00D);
    tick();
    checkOutput("post_rst_en",    32'(sram_en),    32'h1);
    checkOutput("post_rst_wmask", 32'(sram_wmask), 32'hC);
    checkOutput("post_rst_din",   sram_din,        32'hCAFE_F00D);
    tick();
    checkOutput("post_rst_ack",   32'(ack),        32'h1);
    idleBus();
    tick();
    last_rd = 32'h0;

    $display("[TB] strobe outside the 4 KiB window");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3001_0000, 32'h0);
`ifdef WB_SRAM_RANGE_CHECK_EN
    tick();
    checkOutput("oor_err",     32'(err),     32'h1);
    checkOutput("oor_en",      32'(sram_en), 32'h0);
    checkOutput("oor_ack",     32'(ack),     32'h0);
    idleBus();
    tick();
    checkOutput("oor_err_off", 32'(err),     32'h0);
    checkOutput("oor_en_off",  32'(sram_en), 32'h0);
    checkOutput("oor_ack_off", 32'(ack),     32'h0);
`else
    tick();
    checkOutput("alias_en",    32'(sram_en), 32'h1);
    checkOutput("alias_err",   32'(err),     32'h0);
    tick();
    tick();
    checkOutput("alias_ack",   32'(ack),     32'h1);
    checkOutput("alias_dat_o", dat_o,        BANK0);
    last_rd = BANK0;
    idleBus();
    tick();
`endif

    $display("[TB] cycle dropped during read access");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0400, 32'h0);
    tick();
    checkOutput("drop_en", 32'(sram_en), 32'h1);
    idleBus();
    ack_cnt = 0;
    en_cnt  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack) ack_cnt++;
      if (sram_en) en_cnt++;
    end
    checkOutput("drop_no_ack", 32'(ack_cnt), 32'd0);
    checkOutput("drop_no_en",  32'(en_cnt),  32'd0);
    checkOutput("drop_dat_o",  dat_o,        last_rd);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 32'h3000_0020, 32'h55AA_55AA);
    tick();
    checkOutput("sel0_en",    32'(sram_en),    32'h1);
    checkOutput("sel0_web",   32'(sram_web),   32'h0);
    checkOutput("sel0_wmask", 32'(sram_wmask), 32'h0);
    tick();
    checkOutput("sel0_ack",   32'(ack),        32'h1);
    idleBus();
    tick();
    checkOutput("sel0_ack_drop", 32'(ack), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
